// File: rtl/lcd_cmd_executor.sv
// Executes {cmd,payload} words from LCD_command on an HD44780-style 8-bit LCD, with power-up,
// init, setup, E-pulse and post-execution timing. Optional busy-flag polling: LCD_BUSY_POLL_EN.
module lcd_cmd_executor #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned E_PULSE_CYC = 25,
  parameter int unsigned EXEC_CYC    = 2500,
  parameter int unsigned CLEAR_CYC   = 82000,
  parameter int unsigned WAIT2_CYC   = 25000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] DATA,
  output logic        rdy,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  inout  wire  [7:0]  LCD_DATA
);

  typedef enum logic [3:0] {
    StPowerup,
    StSetup,
    StPulse,
    StHold,
    StFetchHi,
    StFetchLo,
    StDecode,
    StDelay,
    StPollSetup,
    StPollPulse
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      cmd_q;
  logic [7:0]       db_q;
  logic             rs_q;
  logic             rw_q;
  logic             en_q;
  logic             rdy_q;
  logic             init_q;
  logic [2:0]       init_idx_q;
  logic [CNT_W-1:0] post_ld;

  // Counter reload value; a zero cycle count behaves as one cycle.
  function automatic logic [CNT_W-1:0] ld(input int unsigned c);
    return (c == 0) ? '0 : CNT_W'(c - 1);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h06;
      default:          return 8'h01;
    endcase
  endfunction

  // Clear-display is the only RS=0 write that can carry 0x01.
  assign post_ld = (!rs_q && db_q == 8'h01) ? ld(CLEAR_CYC) : ld(EXEC_CYC);

  assign rdy    = rdy_q;
  assign LCD_RS = rs_q;
  assign LCD_RW = rw_q;
  assign LCD_EN = en_q;
`ifdef LCD_BUSY_POLL_EN
  assign LCD_DATA = rw_q ? 8'hzz : db_q;
`else
  assign LCD_DATA = db_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StPowerup;
      cnt_q      <= '0;
      cmd_q      <= '0;
      db_q       <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
      rdy_q      <= 1'b0;
      init_q     <= 1'b0;
      init_idx_q <= '0;
    end else begin
      unique case (state_q)
        // Counts up from the reset value of zero, then issues the first init write.
        StPowerup: begin
          if (cnt_q == ld(POWERUP_CYC)) begin
            state_q    <= StSetup;
            init_q     <= 1'b1;
            init_idx_q <= '0;
            rs_q       <= 1'b0;
            db_q       <= init_cmd(3'd0);
            cnt_q      <= ld(SETUP_CYC);
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            state_q <= StPulse;
            cnt_q   <= ld(E_PULSE_CYC);
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            en_q <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            // The first three function-set writes precede a valid busy flag.
            if (init_q && init_idx_q < 3'd3) begin
              state_q <= StHold;
              cnt_q   <= post_ld;
            end else begin
              state_q <= StPollSetup;
              rw_q    <= 1'b1;
              rs_q    <= 1'b0;
              cnt_q   <= ld(SETUP_CYC);
            end
`else
            state_q <= StHold;
            cnt_q   <= post_ld;
`endif
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            if (init_q && init_idx_q != 3'd5) begin
              init_idx_q <= init_idx_q + 3'd1;
              db_q       <= init_cmd(init_idx_q + 3'd1);
              rs_q       <= 1'b0;
              state_q    <= StSetup;
              cnt_q      <= ld(SETUP_CYC);
            end else begin
              init_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= StFetchHi;
              cnt_q   <= CntOne;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StFetchHi: begin
          if (cnt_q == '0) begin
            rdy_q   <= 1'b0;
            state_q <= StFetchLo;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        // DATA changed on the rdy rising edge; latch it on the second cycle after rdy falls.
        StFetchLo: begin
          if (cnt_q == '0) begin
            cmd_q   <= DATA;
            state_q <= StDecode;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StDecode: begin
          case (cmd_q[11:8])
            4'd0: begin
              rs_q    <= 1'b0;
              db_q    <= 8'h01;
              state_q <= StSetup;
              cnt_q   <= ld(SETUP_CYC);
            end
            4'd1: begin
              rs_q    <= 1'b1;
              db_q    <= cmd_q[7:0];
              state_q <= StSetup;
              cnt_q   <= ld(SETUP_CYC);
            end
            4'd2: begin
              rs_q    <= 1'b0;
              db_q    <= 8'h40 | {2'b00, cmd_q[5:0]};
              state_q <= StSetup;
              cnt_q   <= ld(SETUP_CYC);
            end
            4'd3: begin
              rs_q    <= 1'b0;
              db_q    <= 8'h80 | {1'b0, cmd_q[6:0]};
              state_q <= StSetup;
              cnt_q   <= ld(SETUP_CYC);
            end
            4'd4: begin
              state_q <= StDelay;
              cnt_q   <= ld(WAIT2_CYC);
            end
            default: begin
              rdy_q   <= 1'b1;
              state_q <= StFetchHi;
              cnt_q   <= CntOne;
            end
          endcase
        end
        StDelay: begin
          if (cnt_q == '0) begin
            rdy_q   <= 1'b1;
            state_q <= StFetchHi;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
`ifdef LCD_BUSY_POLL_EN
        StPollSetup: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            state_q <= StPollPulse;
            cnt_q   <= ld(E_PULSE_CYC);
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StPollPulse: begin
          if (cnt_q == '0) begin
            en_q <= 1'b0;
            if (LCD_DATA[7]) begin
              state_q <= StPollSetup;
              cnt_q   <= ld(SETUP_CYC);
            end else begin
              // Zero-length hold reuses the init-advance / fetch logic.
              rw_q    <= 1'b0;
              state_q <= StHold;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
`endif
        default: begin
          state_q <= StPowerup;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
